free_list: RTL and testbench
============================

# free_list

Physical-register free list for the rename stage. It supplies new destination tags to dispatch, which writes them into the speculative map table. It takes back superseded tags from retire. On a mispredict it rewinds its speculative head to the architectural head, so every tag allocated by squashed instructions becomes free again. The block is a circular FIFO of PHYS_TAG entries with separate speculative and architectural read pointers.

## Interface
- NUM_ALLOC_PORTS, default `N: dispatch allocation slots.
- NUM_FREE_PORTS, default `N: retire free/commit slots.
- Internal depth is `PHYS_REG_SZ (power of two). Pointers are $clog2(`PHYS_REG_SZ) bits plus a wrap bit.
- clock  input  1  clock.
- reset  input  1  synchronous, active-high.
- alloc_req  input  NUM_ALLOC_PORTS  per-slot request for a destination tag.
- alloc_grant  output  NUM_ALLOC_PORTS  per-slot grant.
- alloc_tags  output  PHYS_TAG[NUM_ALLOC_PORTS]  tag for each granted slot. Don't-care when that slot's grant is low.
- free_en  input  NUM_FREE_PORTS  retire returns a tag.
- free_tags  input  PHYS_TAG[NUM_FREE_PORTS]  tags being returned.
- retire_alloc_en  input  NUM_FREE_PORTS  a retiring instruction had allocated a tag; advances the architectural head.
- restore_en  input  1  mispredict recovery.
- free_count  output  $clog2(`PHYS_REG_SZ+1)  entries between the speculative head and the tail.
- err  output  1  sticky error flag (see Configuration).

## Operation
- Reset:
  - Entry i holds tag `ARCH_REG_SZ+i for i < `PHYS_REG_SZ-`ARCH_REG_SZ.
  - spec_head = arch_head = 0; tail = `PHYS_REG_SZ-`ARCH_REG_SZ.
  - free_count = `PHYS_REG_SZ-`ARCH_REG_SZ; err = 0; alloc_grant = 0.
- Allocation:
  - Requesting slots are ranked k = 0,1,… from low index to high.
  - Slot ranked k gets grant = (k < free_count) and alloc_tags = entry[spec_head+k].
  - spec_head advances by the number of grants.
  - Allocation is FIFO and packed. Ungranted slots do not consume entries.
- Free:
  - Enabled free ports are ranked low to high and written at tail, tail+1, … in rank order.
  - tail advances by popcount(free_en).
  - A free of tag 0 is dropped: it is not written and tail does not advance for it.
- Commit: arch_head advances by popcount(retire_alloc_en). Alloc and retire order are both program order, so arch_head tracks the oldest uncommitted allocation.
- Restore:
  - spec_head_next = arch_head_next, which includes this cycle's retire advance.
  - alloc_grant is forced to 0 that cycle.
  - Frees and commits in the same cycle still take effect.
- free_count = tail − spec_head, using wrap-bit arithmetic. It is recomputed from the next-state pointers.
- Pointer arithmetic wraps modulo depth. The wrap bit distinguishes empty (equal pointers, equal wrap bits) from full (equal index, differing wrap bits).

## Timing
- alloc_grant and alloc_tags are combinational from registered state, alloc_req and restore_en. There is no path from free_en.
- Tags freed in cycle t are grantable from cycle t+1. There is no same-cycle bypass.
- Pointer, count and err updates are registered at the rising edge.
- Reset has priority over restore_en. Reset asserted mid-operation discards all state and returns to the reset contents.
- Simultaneous alloc, free and commit in one cycle are all applied.
- When free_count = 0, all grants are low. Frees in that cycle refill the list for the next cycle.

## Configuration
- FREE_LIST_ERR_EN defined:
  - err sets and holds until reset on any of: a free when the list is full; arch_head advancing past spec_head; restore overlapping an overflow.
  - On an offending free the entry is not written. On an offending commit, arch_head clamps to spec_head.
- FREE_LIST_ERR_EN undefined: err is tied to 0, no checks are performed, and behaviour on such events is undefined.

## Test plan
Values assume `N=3, `ARCH_REG_SZ=32, `PHYS_REG_SZ=64.
- Reset, then alloc_req=3'b111: grant 111, tags 32/33/34; next cycle free_count=29.
- After reset, alloc_req=3'b101: slot0 gets 32, slot2 gets 33, slot1 is not granted; next cycle free_count=30.
- Drain to free_count=1, then alloc_req=111: grant=001 with the last tag; next cycle free_count=0; at 0, any request gets grant=000.
- free_en=3'b011 with tags 5 and 7: next cycle free_count+2; after the list drains, 5 then 7 are allocated in that order. A free of tag 0 leaves free_count unchanged.
- Allocate 32..37 over two cycles, commit 2 via retire_alloc_en, then assert restore_en: grant=000 that cycle; next cycle free_count=30 and the next allocation returns 34.
- Wrap-around: run 200 cycles of random alloc/free, then check free_count against a model and tag uniqueness. With FREE_LIST_ERR_EN, a free while full sets err=1, and err holds until reset.

Source files
------------

// File: rtl/free_list_if.sv
// free_list_if: rename-stage port bundle for the physical-register free list.
//   alloc_req/alloc_grant/alloc_tags : dispatch allocation slots
//   free_en/free_tags                : retire returns superseded tags
//   retire_alloc_en                  : retire commits allocations (arch head)
//   restore_en                       : mispredict recovery
//   free_count, err                  : status back to the rename stage
// Modports: master = rename/retire control, slave = free_list.
// Codebase macros N, ARCH_REG_SZ, PHYS_REG_SZ default here if not set.
`ifndef N
`define N 3
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

interface free_list_if #(
  parameter int unsigned NUM_ALLOC_PORTS = `N,
  parameter int unsigned NUM_FREE_PORTS  = `N
);
  localparam int unsigned TAG_W = $clog2(`PHYS_REG_SZ);
  localparam int unsigned CNT_W = $clog2(`PHYS_REG_SZ + 1);

  logic [NUM_ALLOC_PORTS-1:0]            alloc_req;
  logic [NUM_ALLOC_PORTS-1:0]            alloc_grant;
  logic [NUM_ALLOC_PORTS-1:0][TAG_W-1:0] alloc_tags;
  logic [NUM_FREE_PORTS-1:0]             free_en;
  logic [NUM_FREE_PORTS-1:0][TAG_W-1:0]  free_tags;
  logic [NUM_FREE_PORTS-1:0]             retire_alloc_en;
  logic                                  restore_en;
  logic [CNT_W-1:0]                      free_count;
  logic                                  err;

  modport master (
    output alloc_req, free_en, free_tags, retire_alloc_en, restore_en,
    input  alloc_grant, alloc_tags, free_count, err
  );

  modport slave (
    input  alloc_req, free_en, free_tags, retire_alloc_en, restore_en,
    output alloc_grant, alloc_tags, free_count, err
  );
endinterface

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical tags with a speculative head
// (dispatch allocation), an architectural head (retire commit) and a tail
// (retire frees). A mispredict rewinds the speculative head to the
// architectural head so squashed allocations become free again.
// Ports:
//   clock  : clock
//   reset  : synchronous, active-high
//   bus    : free_list_if.slave (alloc, free, commit, restore, status)
// Optional feature: define FREE_LIST_ERR_EN to enable the sticky err flag
// (free into a full list, commit past the speculative head). Without it
// err is tied low and no checks are made.
`ifndef N
`define N 3
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

module free_list #(
  parameter int unsigned NUM_ALLOC_PORTS = `N,
  parameter int unsigned NUM_FREE_PORTS  = `N
) (
  input logic        clock,
  input logic        reset,
  free_list_if.slave bus
);
  localparam int unsigned DEPTH     = `PHYS_REG_SZ;
  localparam int unsigned ARCH      = `ARCH_REG_SZ;
  localparam int unsigned INIT_FREE = DEPTH - ARCH;
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned PTR_W     = IDX_W + 1;
  localparam int unsigned TAG_W     = IDX_W;
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned AI_W      = (NUM_ALLOC_PORTS > 1) ? $clog2(NUM_ALLOC_PORTS) : 1;
  localparam int unsigned FI_W      = (NUM_FREE_PORTS > 1) ? $clog2(NUM_FREE_PORTS) : 1;

  logic [TAG_W-1:0] entry_q [DEPTH];
  logic [PTR_W-1:0] spec_head_q, arch_head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic [PTR_W-1:0] n_grant, n_retire, spec_adv, arch_next, spec_next, tail_next;
  logic [NUM_FREE_PORTS-1:0]            wr_ok;
  logic [NUM_FREE_PORTS-1:0][IDX_W-1:0] wr_idx;
`ifdef FREE_LIST_ERR_EN
  logic overflow, over_commit, err_q;
`endif

  // Packed in-order allocation: k-th requester takes entry[spec_head+k]
  always_comb begin
    n_grant         = '0;
    bus.alloc_grant = '0;
    bus.alloc_tags  = '0;
    for (int unsigned i = 0; i < NUM_ALLOC_PORTS; i++) begin
      bus.alloc_tags[AI_W'(i)] = entry_q[IDX_W'(spec_head_q + n_grant)];
      if (bus.alloc_req[AI_W'(i)] && !bus.restore_en && (PTR_W'(count_q) > n_grant)) begin
        bus.alloc_grant[AI_W'(i)] = 1'b1;
        n_grant = n_grant + PTR_W'(1);
      end
    end
  end

  // Frees append at the tail in port order; tag 0 is never returned
  always_comb begin
    tail_next = tail_q;
    wr_ok     = '0;
    wr_idx    = '0;
`ifdef FREE_LIST_ERR_EN
    overflow  = 1'b0;
`endif
    for (int unsigned j = 0; j < NUM_FREE_PORTS; j++) begin
      wr_idx[FI_W'(j)] = IDX_W'(tail_next);
      if (bus.free_en[FI_W'(j)] && (bus.free_tags[FI_W'(j)] != '0)) begin
`ifdef FREE_LIST_ERR_EN
        // Slots from arch_head up are still owned by uncommitted allocations
        if ((tail_next - arch_head_q) == PTR_W'(DEPTH)) begin
          overflow = 1'b1;
        end else begin
          wr_ok[FI_W'(j)] = 1'b1;
          tail_next       = tail_next + PTR_W'(1);
        end
`else
        wr_ok[FI_W'(j)] = 1'b1;
        tail_next       = tail_next + PTR_W'(1);
`endif
      end
    end
  end

  // Commit advances arch_head; restore rewinds spec_head to the new arch_head
  always_comb begin
    n_retire = '0;
    for (int unsigned k = 0; k < NUM_FREE_PORTS; k++) begin
      n_retire = n_retire + PTR_W'(bus.retire_alloc_en[FI_W'(k)]);
    end
    spec_adv  = spec_head_q + n_grant;
    arch_next = arch_head_q + n_retire;
`ifdef FREE_LIST_ERR_EN
    over_commit = n_retire > (spec_adv - arch_head_q);
    if (over_commit) begin
      arch_next = spec_adv;
    end
`endif
    spec_next = bus.restore_en ? arch_next : spec_adv;
  end

  // State update; reset reloads tags ARCH..DEPTH-1 as the free pool
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[IDX_W'(i)] <= (i < INIT_FREE) ? TAG_W'(ARCH + i) : '0;
      end
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= PTR_W'(INIT_FREE);
      count_q     <= CNT_W'(INIT_FREE);
    end else begin
      for (int unsigned j = 0; j < NUM_FREE_PORTS; j++) begin
        if (wr_ok[FI_W'(j)]) begin
          entry_q[wr_idx[FI_W'(j)]] <= bus.free_tags[FI_W'(j)];
        end
      end
      spec_head_q <= spec_next;
      arch_head_q <= arch_next;
      tail_q      <= tail_next;
      count_q     <= CNT_W'(tail_next - spec_next);
    end
  end

  assign bus.free_count = count_q;

`ifdef FREE_LIST_ERR_EN
  // Sticky error; a restore coinciding with an overflowing free is caught
  // through the overflow term since the free itself is the offence
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (overflow || over_commit) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed table vectors plus hand sequences and a random
// alloc/free/commit run against a queue model, for free_list.
`ifndef N
`define N 3
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

module tb_free_list;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  free_list_if #(.NUM_ALLOC_PORTS(3), .NUM_FREE_PORTS(3)) bus();

  free_list #(.NUM_ALLOC_PORTS(3), .NUM_FREE_PORTS(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit              do_reset;
    logic [2:0]      req;
    logic [2:0]      fen;
    logic [2:0][5:0] ft;
    logic [2:0]      ret;
    logic            rs;
    logic [2:0]      exp_grant;
    logic [2:0][5:0] exp_tags;
    int              exp_count;
  } vec_t;

  int   nvec = 0;
  int   nerr = 0;
  logic exp_err = 1'b0;
  vec_t tbl[$];

  function automatic vec_t mk(input bit d, input logic [2:0] req, input logic [2:0] fen,
                              input logic [5:0] f0, input logic [5:0] f1, input logic [5:0] f2,
                              input logic [2:0] ret, input logic rs, input logic [2:0] g,
                              input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2,
                              input int cnt);
    vec_t v;
    v.do_reset = d;   v.req = req;  v.fen = fen;
    v.ft[0] = f0;     v.ft[1] = f1; v.ft[2] = f2;
    v.ret = ret;      v.rs = rs;    v.exp_grant = g;
    v.exp_tags[0] = t0; v.exp_tags[1] = t1; v.exp_tags[2] = t2;
    v.exp_count = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.alloc_req       = '0;
    bus.free_en         = '0;
    bus.free_tags       = '0;
    bus.retire_alloc_en = '0;
    bus.restore_en      = 1'b0;
  endtask

  task automatic do_reset(input logic with_restore);
    @(negedge clock);
    drive_idle();
    bus.alloc_req  = 3'b111;
    bus.restore_en = with_restore;
    reset = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
    drive_idle();
  endtask

  task automatic apply_vec(input vec_t v, input int id);
    if (v.do_reset) do_reset(1'b0);
    @(negedge clock);
    bus.alloc_req       = v.req;
    bus.free_en         = v.fen;
    bus.free_tags       = v.ft;
    bus.retire_alloc_en = v.ret;
    bus.restore_en      = v.rs;
    #2;
    check($sformatf("v%0d grant", id), 32'(bus.alloc_grant), 32'(v.exp_grant));
    for (int i = 0; i < 3; i++) begin
      if (v.exp_grant[i]) begin
        check($sformatf("v%0d tag%0d", id, i), 32'(bus.alloc_tags[i]), 32'(v.exp_tags[i]));
      end
    end
    @(posedge clock);
    #1;
    check($sformatf("v%0d free_count", id), 32'(bus.free_count), 32'(v.exp_count));
    check($sformatf("v%0d err", id), 32'(bus.err), 32'(exp_err));
  endtask

  // Random alloc/free/commit traffic checked against a queue of free tags
  task automatic run_random();
    logic [5:0] fq[$];
    logic [5:0] held[$];
    int         uncommitted = 0;
    int         dup;
    bit         seen [64];
    do_reset(1'b0);
    for (int t = 0; t < 32; t++) fq.push_back(6'(32 + t));
    for (int cyc = 0; cyc < 200; cyc++) begin
      logic [2:0]      req;
      logic [2:0]      fen;
      logic [2:0]      ret;
      logic [2:0][5:0] ft;
      logic [5:0]      freed[$];
      int              rank;
      int              k;
      @(negedge clock);
      req = 3'($urandom);
      fen = 3'($urandom);
      ret = 3'($urandom);
      ft  = '0;
      for (int j = 0; j < 3; j++) begin
        if (fen[j]) begin
          if (held.size() > 0) begin
            int idx;
            idx   = $urandom_range(0, held.size() - 1);
            ft[j] = held[idx];
            freed.push_back(held[idx]);
            held.delete(idx);
          end else begin
            fen[j] = 1'b0;
          end
        end
      end
      k = 0;
      for (int j = 0; j < 3; j++) begin
        if (ret[j]) begin
          if (k < uncommitted) k++;
          else ret[j] = 1'b0;
        end
      end
      uncommitted -= k;
      bus.alloc_req       = req;
      bus.free_en         = fen;
      bus.free_tags       = ft;
      bus.retire_alloc_en = ret;
      bus.restore_en      = 1'b0;
      #2;
      rank = 0;
      for (int i = 0; i < 3; i++) begin
        logic g;
        g = req[i] && (rank < fq.size());
        check($sformatf("rnd%0d grant%0d", cyc, i), 32'(bus.alloc_grant[i]), 32'(g));
        if (g) begin
          check($sformatf("rnd%0d tag%0d", cyc, i), 32'(bus.alloc_tags[i]), 32'(fq[rank]));
          rank++;
        end
      end
      for (int r = 0; r < rank; r++) held.push_back(fq.pop_front());
      uncommitted += rank;
      foreach (freed[f]) fq.push_back(freed[f]);
      @(posedge clock);
      #1;
      check($sformatf("rnd%0d free_count", cyc), 32'(bus.free_count), 32'(fq.size()));
    end
    @(negedge clock);
    drive_idle();
    dup = 0;
    foreach (seen[s]) seen[s] = 1'b0;
    foreach (fq[i]) begin
      if (seen[fq[i]]) dup++;
      seen[fq[i]] = 1'b1;
    end
    foreach (held[i]) begin
      if (seen[held[i]]) dup++;
      seen[held[i]] = 1'b1;
    end
    check("rnd tag uniqueness", 32'(dup), 32'd0);
    check("rnd tag population", 32'(fq.size() + held.size()), 32'd32);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive_idle();

    //            d req fen f0 f1 f2 ret rs  g  t0 t1 t2  cnt
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0, 7, 32, 33, 34, 29));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 5, 32, 0, 33, 30));
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 2, 0, 34, 0, 29));
    // allocate 32..37, commit two, restore
    tbl.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 7, 32, 33, 34, 29));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0, 7, 35, 36, 37, 26));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 26));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 30));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 34, 0, 0, 29));
    // restore with a same-cycle commit uses the advanced arch head
    tbl.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 7, 32, 33, 34, 29));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 31));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 3, 33, 34, 0, 29));
    // frees, tag-0 drop, simultaneous alloc/free/commit
    tbl.push_back(mk(1, 0, 3, 5, 7, 0, 0, 0, 0, 0, 0, 0, 34));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 34));
    tbl.push_back(mk(0, 0, 7, 0, 9, 0, 0, 0, 0, 0, 0, 0, 35));
    tbl.push_back(mk(0, 7, 4, 0, 0, 20, 0, 0, 7, 32, 33, 34, 33));
    tbl.push_back(mk(0, 3, 1, 21, 0, 0, 7, 0, 3, 35, 36, 0, 32));

    foreach (tbl[n]) apply_vec(tbl[n], n);

    // Drain to empty: freed 5 and 7 come out after the reset pool, in order
    apply_vec(mk(1, 0, 3, 5, 7, 0, 0, 0, 0, 0, 0, 0, 34), 100);
    for (int c = 0; c < 10; c++) begin
      apply_vec(mk(0, 7, 0, 0, 0, 0, 0, 0, 7, 6'(32 + 3 * c), 6'(33 + 3 * c), 6'(34 + 3 * c),
                   34 - 3 * (c + 1)), 101 + c);
    end
    apply_vec(mk(0, 7, 0, 0, 0, 0, 0, 0, 7, 62, 63, 5, 1), 111);
    apply_vec(mk(0, 7, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0), 112);
    apply_vec(mk(0, 7, 6, 0, 10, 11, 0, 0, 0, 0, 0, 0, 2), 113);
    apply_vec(mk(0, 6, 0, 0, 0, 0, 0, 0, 6, 0, 10, 11, 0), 114);

    // Reset mid-operation wins over restore
    do_reset(1'b1);
    apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32), 120);
    apply_vec(mk(0, 7, 0, 0, 0, 0, 0, 0, 7, 32, 33, 34, 29), 121);

`ifdef FREE_LIST_ERR_EN
    // Fill to 64, then one more free sets the sticky error
    apply_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32), 200);
    for (int c = 0; c < 10; c++) begin
      apply_vec(mk(0, 0, 7, 6'(3 * c + 1), 6'(3 * c + 2), 6'(3 * c + 3), 0, 0, 0, 0, 0, 0,
                   32 + 3 * (c + 1)), 201 + c);
    end
    apply_vec(mk(0, 0, 3, 31, 32, 0, 0, 0, 0, 0, 0, 0, 64), 211);
    exp_err = 1'b1;
    apply_vec(mk(0, 0, 1, 40, 0, 0, 0, 0, 0, 0, 0, 0, 64), 212);
    apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64), 213);
    apply_vec(mk(0, 7, 0, 0, 0, 0, 0, 0, 7, 32, 33, 34, 61), 214);
    exp_err = 1'b0;
    apply_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32), 215);
`endif

    run_random();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
